// File: rtl/avalon_pkg.sv
// avalon_pkg: shared widths, limits and helpers for the ready-latency adapter.
package avalon_pkg;
   localparam int MAX_READY_LATENCY = 4;
   localparam int DEFAULT_WIDTH = 32;
   typedef logic [DEFAULT_WIDTH-1:0] beat_t;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/avalon_st_buf.sv
// avalon_st_buf: DEPTH x WIDTH circular buffer with combinational head read.
module avalon_st_buf
   import avalon_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [cnt_w(DEPTH)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_head, r_tail;
   logic [CW-1:0] r_count;
   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction
   always_ff @(posedge clk)
      if (push) r_mem[r_tail] <= wdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (push) r_tail <= nxt(r_tail);
         if (pop) r_head <= nxt(r_head);
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   end
   assign rdata = r_mem[r_head];
   assign count = r_count;
endmodule

// File: rtl/avalon_st_rl_adapter.sv
// avalon_st_rl_adapter: converts a ready-latency>=1 Avalon-ST source into a ready-latency-0 stream.
module avalon_st_rl_adapter
   import avalon_pkg::*;
#(
   parameter int DATABITS_PER_SYMBOL = 8,
   parameter int SYMBOLS_PER_BEAT    = 4,
   parameter int WIDTH               = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
   parameter int READY_LATENCY       = 1,
   parameter int BUF_DEPTH           = READY_LATENCY + 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [cnt_w(BUF_DEPTH)-1:0] occupancy,
   output logic                        proto_err
);
   localparam int CW = cnt_w(BUF_DEPTH);
   localparam int SW = cnt_w(BUF_DEPTH + READY_LATENCY);
   if (READY_LATENCY < 1 || READY_LATENCY > MAX_READY_LATENCY) begin : g_bad_rl
      $error("READY_LATENCY out of range 1..%0d", MAX_READY_LATENCY);
   end
   if (BUF_DEPTH < READY_LATENCY + 2) begin : g_bad_depth
      $error("BUF_DEPTH must be at least READY_LATENCY+2");
   end
   logic [READY_LATENCY-1:0] r_hist;
   logic                     r_proto_err;
   logic                     w_push, w_pop;
   logic [WIDTH-1:0]         w_rdata;
   logic [CW-1:0]            w_count;
   logic [SW-1:0]            w_used;
   // Buffered beats plus credits still in flight must never exceed the buffer.
   always_comb begin
      w_used = SW'(w_count);
      for (int i = 0; i < READY_LATENCY; i++) w_used = w_used + SW'(r_hist[i]);
   end
   assign in_ready  = !rst && (w_used < SW'(BUF_DEPTH));
   assign out_valid = !rst && (w_count != '0);
   assign out_data  = out_valid ? w_rdata : '0;
   assign w_push    = in_valid && r_hist[READY_LATENCY-1];
   assign w_pop     = out_valid && out_ready;
   assign occupancy = w_count;
   assign proto_err = r_proto_err;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist      <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_hist      <= (r_hist << 1) | READY_LATENCY'(in_ready);
         r_proto_err <= r_proto_err | (in_valid && !r_hist[READY_LATENCY-1]);
      end
   end
   avalon_st_buf #(.DEPTH(BUF_DEPTH), .WIDTH(WIDTH)) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (w_push),
      .pop  (w_pop),
      .wdata(in_data),
      .rdata(w_rdata),
      .count(w_count)
   );
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (w_count == CW'(BUF_DEPTH)) |-> !w_push);
endmodule

// File: tb/tb_avalon_st_rl_adapter.sv
// tb_avalon_st_rl_adapter: directed scoreboard bench for L=1/depth 3 and L=3/depth 5 instances.
module tb_avalon_st_rl_adapter;
   import avalon_pkg::*;
   logic clk, rst;
   beat_t in_data1, out_data1, in_data3, out_data3;
   logic in_valid1, in_ready1, out_valid1, out_ready1, proto_err1;
   logic in_valid3, in_ready3, out_valid3, out_ready3, proto_err3;
   logic [1:0] occ1;
   logic [2:0] occ3, occ_max3;
   beat_t tx1[$], exp1[$], tx3[$], exp3[$];
   logic bad_req;
   beat_t bad_val;
   int n_chk = 0, n_pass = 0, rx1 = 0, rx3 = 0;

   avalon_st_rl_adapter #(.READY_LATENCY(1), .BUF_DEPTH(3)) u_dut1 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .occupancy(occ1), .proto_err(proto_err1));
   avalon_st_rl_adapter #(.READY_LATENCY(3), .BUF_DEPTH(5)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .occupancy(occ3), .proto_err(proto_err3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compliant L=1 source: sends only when in_ready was high one clock earlier.
   initial begin
      logic h1, s_rdy1, s_rst1;
      in_valid1 = 1'b0;
      in_data1 = '0;
      h1 = 1'b0;
      forever begin
         @(negedge clk);
         s_rdy1 = in_ready1;
         s_rst1 = rst;
         @(posedge clk);
         #2;
         h1 = s_rst1 ? 1'b0 : s_rdy1;
         if (tx1.size() != 0 && h1) begin
            in_data1 = tx1.pop_front();
            in_valid1 = 1'b1;
            exp1.push_back(in_data1);
         end else if (bad_req) begin
            in_data1 = bad_val;
            in_valid1 = 1'b1;
            bad_req = 1'b0;
         end else in_valid1 = 1'b0;
      end
   end

   // Compliant L=3 source.
   initial begin
      logic [2:0] h3;
      logic s_rdy3, s_rst3;
      in_valid3 = 1'b0;
      in_data3 = '0;
      h3 = '0;
      forever begin
         @(negedge clk);
         s_rdy3 = in_ready3;
         s_rst3 = rst;
         @(posedge clk);
         #2;
         h3 = s_rst3 ? 3'b000 : {h3[1:0], s_rdy3};
         if (tx3.size() != 0 && h3[2]) begin
            in_data3 = tx3.pop_front();
            in_valid3 = 1'b1;
            exp3.push_back(in_data3);
         end else in_valid3 = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         if (exp1.size() == 0) chk("out1_extra_beat", out_data1, 32'hFFFF_FFFF);
         else chk("out1_data", out_data1, exp1.pop_front());
         rx1++;
      end
   end

   initial occ_max3 = '0;
   always @(negedge clk) begin
      if (occ3 > occ_max3) occ_max3 = occ3;
      if (!rst && out_valid3 && out_ready3) begin
         if (exp3.size() == 0) chk("out3_extra_beat", out_data3, 32'hFFFF_FFFF);
         else chk("out3_data", out_data3, exp3.pop_front());
         rx3++;
      end
   end

   task automatic drain1(input string nm);
      int n = 0;
      while ((tx1.size() != 0 || exp1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 200), 32'd1);
      @(negedge clk);
      chk({nm, "_occ"}, 32'(occ1), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rx_b;
      rst = 1'b1;
      out_ready1 = 1'b0;
      out_ready3 = 1'b0;
      bad_req = 1'b0;
      bad_val = 32'h0000_0BAD;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready1", 32'(in_ready1), 32'd0);
      chk("rst_out_valid1", 32'(out_valid1), 32'd0);
      chk("rst_out_data1", out_data1, 32'd0);
      chk("rst_occ1", 32'(occ1), 32'd0);
      chk("rst_proto_err1", 32'(proto_err1), 32'd0);
      chk("rst_in_ready3", 32'(in_ready3), 32'd0);

      // full-rate stream: first beat visible 2 clocks after reset release
      step();
      rst = 1'b0;
      out_ready1 = 1'b1;
      for (int i = 0; i < 8; i++) tx1.push_back(32'h11 + 32'(i));
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t1_valid", 32'(out_valid1), 32'd1);
         chk("t1_data", out_data1, 32'h11 + 32'(i));
         chk("t1_in_ready", 32'(in_ready1), 32'd1);
      end
      drain1("t1_drain");

      // stalled sink: buffer saturates, credits stop
      step();
      out_ready1 = 1'b0;
      for (int i = 0; i < 5; i++) tx1.push_back(32'h21 + 32'(i));
      repeat (10) @(negedge clk);
      chk("t2_occ", 32'(occ1), 32'd3);
      chk("t2_in_ready", 32'(in_ready1), 32'd0);
      chk("t2_out_valid", 32'(out_valid1), 32'd1);
      chk("t2_head", out_data1, 32'h21);
      step();
      tx1.delete();
      out_ready1 = 1'b1;
      drain1("t2_drain");

      // beat sent without a credit is dropped and flagged
      step();
      out_ready1 = 1'b0;
      for (int i = 0; i < 4; i++) tx1.push_back(32'h31 + 32'(i));
      repeat (10) @(negedge clk);
      chk("t3_occ_full", 32'(occ1), 32'd3);
      chk("t3_err_before", 32'(proto_err1), 32'd0);
      step();
      tx1.delete();
      bad_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t3_err_set", 32'(proto_err1), 32'd1);
      chk("t3_occ_after_bad", 32'(occ1), 32'd3);
      rx_b = rx1;
      step();
      out_ready1 = 1'b1;
      drain1("t3_drain");
      chk("t3_rx_count", 32'(rx1 - rx_b), 32'd3);
      chk("t3_err_sticky", 32'(proto_err1), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t3_err_cleared", 32'(proto_err1), 32'd0);

      // reset with two beats buffered and one in flight
      step();
      out_ready1 = 1'b0;
      for (int i = 0; i < 3; i++) tx1.push_back(32'h51 + 32'(i));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (occ1 != 2'd1 && n < 20);
      chk("t5_fill", 32'(n < 20), 32'd1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_in_ready", 32'(in_ready1), 32'd0);
      chk("t5_rst_out_valid", 32'(out_valid1), 32'd0);
      chk("t5_rst_out_data", out_data1, 32'd0);
      step();
      rst = 1'b0;
      tx1.delete();
      exp1.delete();
      @(negedge clk);
      chk("t5_out_valid", 32'(out_valid1), 32'd0);
      chk("t5_occ", 32'(occ1), 32'd0);
      chk("t5_err", 32'(proto_err1), 32'd0);
      step();
      out_ready1 = 1'b1;
      rx_b = rx1;
      for (int i = 0; i < 4; i++) tx1.push_back(32'h61 + 32'(i));
      drain1("t5_drain");
      chk("t5_rx_count", 32'(rx1 - rx_b), 32'd4);
      chk("t5_err_clean", 32'(proto_err1), 32'd0);

      // steady push+pop at occupancy 1
      step();
      for (int i = 0; i < 12; i++) tx1.push_back(32'h71 + 32'(i));
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t6_occ", 32'(occ1), 32'd1);
         chk("t6_data", out_data1, 32'h71 + 32'(i));
      end
      drain1("t6_drain");

      // L=3, depth 5, sink toggling every clock
      step();
      for (int i = 0; i < 40; i++) tx3.push_back(32'($urandom()));
      n = 0;
      while ((tx3.size() != 0 || exp3.size() != 0) && n < 400) begin
         step();
         out_ready3 = ~out_ready3;
         n++;
      end
      chk("t4_done", 32'(n < 400), 32'd1);
      chk("t4_rx_count", 32'(rx3), 32'd40);
      chk("t4_occ_max_le5", 32'(occ_max3 <= 3'd5), 32'd1);
      chk("t4_proto_err", 32'(proto_err3), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
